pe_bf16_os: RTL and testbench

Output-stationary BF16×BF16→FP32 multiply-accumulate processing element for the next-generation systolic array. It replaces the single-cycle integer-add PE with three capabilities: an IEEE-style FP32 accumulator, valid-qualified operand forwarding, and a two-stage multiply/accumulate pipeline. It also adds a daisy-chained drain path, so finished tiles shift out of the array column while the next tile starts accumulating. Tiles of PEs form an N×M grid: `a` flows east, `b` flows south and results drain south.

---
 rtl/pe_bf16_os.sv | 194 +++++++++++++++++++
 tb/tb_pe_bf16_os.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_bf16_os.sv
// Output-stationary BF16 x BF16 -> FP32 MAC processing element with operand
// forwarding, a two-stage multiply/accumulate pipeline and a daisy-chained drain.
module pe_bf16_os #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FTZ        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  a_vld_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  b_vld_in,
  input  logic                  acc_clr,
  input  logic                  drain,
  input  logic [ACC_WIDTH-1:0]  c_in,
  input  logic                  c_vld_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  a_vld_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  b_vld_out,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_vld_out,
  output logic                  busy
);

  if (DATA_WIDTH != 16) begin : g_chk_dw
    $error("pe_bf16_os: DATA_WIDTH must be 16 (BF16)");
  end
  if (ACC_WIDTH != 32) begin : g_chk_aw
    $error("pe_bf16_os: ACC_WIDTH must be 32 (FP32)");
  end
  if (FTZ != 1) begin : g_chk_ftz
    $error("pe_bf16_os: only FTZ=1 is supported");
  end

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0] p, acc, mul_res, add_res;
  logic        p_vld, p_clr;
  logic        issue;

  assign issue = a_vld_in & b_vld_in;
  assign busy  = p_vld;

  // ---------------- stage 1: exact BF16 product ----------------
  logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, ms;
  logic [15:0]       prod;
  logic signed [9:0] pe;
  logic [22:0]       pfrac;

  always_comb begin
    a_nan  = (a_in[14:7] == 8'hFF) && (a_in[6:0] != '0);
    a_inf  = (a_in[14:7] == 8'hFF) && (a_in[6:0] == '0);
    a_zero = (a_in[14:7] == 8'h00);
    b_nan  = (b_in[14:7] == 8'hFF) && (b_in[6:0] != '0);
    b_inf  = (b_in[14:7] == 8'hFF) && (b_in[6:0] == '0);
    b_zero = (b_in[14:7] == 8'h00);
    ms     = a_in[15] ^ b_in[15];
    prod   = {8'b0, 1'b1, a_in[6:0]} * {8'b0, 1'b1, b_in[6:0]};
    pe     = $signed({2'b0, a_in[14:7]}) + $signed({2'b0, b_in[14:7]})
           - 10'sd127 + $signed({9'b0, prod[15]});
    pfrac  = prod[15] ? {prod[14:0], 8'b0} : {prod[13:0], 9'b0};

    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      mul_res = QNAN;
    else if (a_inf || b_inf)
      mul_res = {ms, 8'hFF, 23'b0};
    else if (a_zero || b_zero)
      mul_res = {ms, 31'b0};
    else if (pe >= 10'sd255)
      mul_res = {ms, 8'hFF, 23'b0};
    else if (pe <= 10'sd0)
      mul_res = {ms, 31'b0};
    else
      mul_res = {ms, pe[7:0], pfrac};
  end

  // ---------------- stage 2: FP32 add acc + p, RNE, FTZ ----------------
  logic              xs, ys, bs;
  logic [7:0]        xe, ye, be, le, dsh;
  logic [22:0]       xf, yf, bfr, lfr, afrac;
  logic              x_nan, x_inf, x_zero, y_nan, y_inf, y_zero;
  logic [26:0]       x27, y27, m27;
  logic [49:0]       wide;
  logic [27:0]       s28;
  logic [4:0]        lz;
  logic signed [9:0] e10;
  logic              round_up;
  logic [24:0]       m25;

  always_comb begin
    xs = acc[31]; xe = acc[30:23]; xf = acc[22:0];
    ys = p[31];   ye = p[30:23];   yf = p[22:0];
    x_nan  = (xe == 8'hFF) && (xf != '0);
    x_inf  = (xe == 8'hFF) && (xf == '0);
    x_zero = (xe == 8'h00);
    y_nan  = (ye == 8'hFF) && (yf != '0);
    y_inf  = (ye == 8'hFF) && (yf == '0);
    y_zero = (ye == 8'h00);

    if ({xe, xf} >= {ye, yf}) begin
      bs = xs; be = xe; bfr = xf; le = ye; lfr = yf;
    end else begin
      bs = ys; be = ye; bfr = yf; le = xe; lfr = xf;
    end

    // Beyond 26 places the smaller operand only contributes to sticky.
    dsh  = ((be - le) > 8'd26) ? 8'd26 : (be - le);
    x27  = {1'b1, bfr, 3'b000};
    wide = {1'b1, lfr, 26'b0} >> dsh;
    y27  = {wide[49:24], |wide[23:0]};
    s28  = (xs == ys) ? ({1'b0, x27} + {1'b0, y27}) : ({1'b0, x27} - {1'b0, y27});

    lz = '0;
    for (int unsigned i = 0; i < 27; i++)
      if (s28[i]) lz = 5'(26 - i);

    if (s28[27]) begin
      m27 = {s28[27:2], s28[1] | s28[0]};
      e10 = $signed({2'b0, be}) + 10'sd1;
    end else begin
      m27 = s28[26:0] << lz;
      e10 = $signed({2'b0, be}) - $signed({5'b0, lz});
    end

    round_up = m27[2] & (m27[1] | m27[0] | m27[3]);
    m25      = {1'b0, m27[26:3]} + {24'b0, round_up};
    if (m25[24]) begin
      e10   = e10 + 10'sd1;
      afrac = m25[23:1];
    end else begin
      afrac = m25[22:0];
    end

    if (x_nan || y_nan || (x_inf && y_inf && (xs != ys)))
      add_res = QNAN;
    else if (x_inf)
      add_res = acc;
    else if (y_inf)
      add_res = p;
    else if (x_zero && y_zero)
      add_res = {xs & ys, 31'b0};
    else if (x_zero)
      add_res = p;
    else if (y_zero)
      add_res = acc;
    else if (s28 == '0)
      add_res = '0;
    else if (e10 >= 10'sd255)
      add_res = {bs, 8'hFF, 23'b0};
    else if (e10 <= 10'sd0)
      add_res = {bs, 31'b0};
    else
      add_res = {bs, e10[7:0], afrac};
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      c_out     <= '0;
      c_vld_out <= 1'b0;
      p         <= '0;
      p_vld     <= 1'b0;
      p_clr     <= 1'b0;
      acc       <= '0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
      p_vld     <= issue;
      if (issue) begin
        p     <= mul_res;
        p_clr <= acc_clr;
      end
      // Drain hands acc to the chain; a pending product seeds the next tile.
      if (drain) begin
        c_out     <= acc;
        c_vld_out <= 1'b1;
        acc       <= p_vld ? p : '0;
      end else begin
        c_out     <= c_in;
        c_vld_out <= c_vld_in;
        if (p_vld) acc <= p_clr ? p : add_res;
      end
    end
  end

endmodule

// File: tb/tb_pe_bf16_os.sv
// Self-checking bench for pe_bf16_os: directed spec scenarios followed by
// randomized traffic against a real-arithmetic reference model.
module tb_pe_bf16_os;

  logic        clk, rst;
  logic [15:0] a_in, b_in, a_out, b_out;
  logic        a_vld_in, b_vld_in, a_vld_out, b_vld_out;
  logic        acc_clr, drain, c_vld_in, c_vld_out, busy;
  logic [31:0] c_in, c_out;

  int checks = 0;
  int errors = 0;

  pe_bf16_os #(.DATA_WIDTH(16), .ACC_WIDTH(32), .FTZ(1)) dut (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
    .acc_clr(acc_clr), .drain(drain), .c_in(c_in), .c_vld_in(c_vld_in),
    .a_out(a_out), .a_vld_out(a_vld_out), .b_out(b_out), .b_vld_out(b_vld_out),
    .c_out(c_out), .c_vld_out(c_vld_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference arithmetic ----------------
  function automatic real pow2(int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  // Round a real to FP32 (nearest-even), flushing tiny results to signed zero.
  function automatic logic [31:0] enc(real v);
    logic s; real m, f, fl; int e, fi, ev;
    s = (v < 0.0);
    m = s ? -v : v;
    if (m == 0.0) return {s, 31'b0};
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    f  = m * 8388608.0;
    fl = $floor(f);
    fi = $rtoi(fl);
    if ((f - fl > 0.5) || ((f - fl == 0.5) && fi[0])) fi++;
    if (fi == (1 << 24)) begin fi = 1 << 23; e++; end
    if (e < -126) return {s, 31'b0};
    if (e > 127) return {s, 8'hFF, 23'b0};
    ev = e + 127;
    return {s, ev[7:0], fi[22:0]};
  endfunction

  function automatic real bf_val(logic [15:0] x);
    return (x[15] ? -1.0 : 1.0) * (1.0 + real'(x[6:0]) / 128.0) * pow2(int'(x[14:7]) - 127);
  endfunction

  function automatic real fp_val(logic [31:0] x);
    return (x[31] ? -1.0 : 1.0) * (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
  endfunction

  function automatic logic [31:0] bf_mul(logic [15:0] a, logic [15:0] b);
    logic an, ai, az, bn, bi, bz, s;
    an = (a[14:7] == 8'hFF) && (a[6:0] != 0); ai = (a[14:7] == 8'hFF) && (a[6:0] == 0);
    bn = (b[14:7] == 8'hFF) && (b[6:0] != 0); bi = (b[14:7] == 8'hFF) && (b[6:0] == 0);
    az = (a[14:7] == 0); bz = (b[14:7] == 0);
    s  = a[15] ^ b[15];
    if (an || bn || (ai && bz) || (az && bi)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'b0};
    if (az || bz) return {s, 31'b0};
    return enc(bf_val(a) * bf_val(b));
  endfunction

  function automatic logic [31:0] fp_add(logic [31:0] x, logic [31:0] y);
    logic xn, xi, xz, yn, yi, yz;
    real v;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0); xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0); yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz = (x[30:23] == 0); yz = (y[30:23] == 0);
    if (xn || yn) return 32'h7FC00000;
    if (xi && yi) return (x[31] == y[31]) ? x : 32'h7FC00000;
    if (xi) return x;
    if (yi) return y;
    if (xz && yz) return {x[31] & y[31], 31'b0};
    if (xz) return y;
    if (yz) return x;
    v = fp_val(x) + fp_val(y);
    if (v == 0.0) return 32'h0;
    return enc(v);
  endfunction

  // ---------------- cycle-level model state ----------------
  logic [15:0] m_a, m_b;
  logic        m_av, m_bv, m_cv, m_pv, m_pclr;
  logic [31:0] m_c, m_p, m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic chk_outputs();
    chk("a_out", {16'b0, a_out}, {16'b0, m_a});
    chk("a_vld_out", {31'b0, a_vld_out}, {31'b0, m_av});
    chk("b_out", {16'b0, b_out}, {16'b0, m_b});
    chk("b_vld_out", {31'b0, b_vld_out}, {31'b0, m_bv});
    chk("c_out", c_out, m_c);
    chk("c_vld_out", {31'b0, c_vld_out}, {31'b0, m_cv});
    chk("busy", {31'b0, busy}, {31'b0, m_pv});
  endtask

  task automatic cyc(input logic [15:0] a, input logic av, input logic [15:0] b, input logic bv,
                     input logic clr, input logic drn, input logic [31:0] c, input logic cv);
    a_in = a; a_vld_in = av; b_in = b; b_vld_in = bv;
    acc_clr = clr; drain = drn; c_in = c; c_vld_in = cv;
    @(posedge clk);
    m_a = a; m_av = av; m_b = b; m_bv = bv;
    if (drn) begin
      m_c = m_acc; m_cv = 1'b1;
      m_acc = m_pv ? m_p : 32'h0;
    end else begin
      m_c = c; m_cv = cv;
      if (m_pv) m_acc = m_pclr ? m_p : fp_add(m_acc, m_p);
    end
    m_pv = av & bv;
    if (av & bv) begin m_p = bf_mul(a, b); m_pclr = clr; end
    #1;
    chk_outputs();
  endtask

  task automatic mac(input logic [15:0] a, input logic [15:0] b, input logic clr);
    cyc(a, 1'b1, b, 1'b1, clr, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic idle();
    cyc(16'($urandom), 1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_drain();
    cyc(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'($urandom), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in = 16'hFFFF; a_vld_in = 1'b1; b_in = 16'hFFFF; b_vld_in = 1'b1;
    acc_clr = 1'b0; drain = 1'b1; c_in = 32'hFFFFFFFF; c_vld_in = 1'b1;
    @(posedge clk);
    m_a = '0; m_b = '0; m_av = 0; m_bv = 0; m_c = '0; m_cv = 0;
    m_p = '0; m_pv = 0; m_pclr = 0; m_acc = '0;
    #1;
    chk_outputs();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_bf16();
    int unsigned k;
    logic s; logic [6:0] mt; logic [7:0] ex;
    k  = $urandom_range(0, 23);
    s  = 1'($urandom_range(0, 1));
    mt = 7'($urandom);
    ex = 8'($urandom_range(118, 136));
    case (k)
      0: return {s, 15'b0};
      1: return {s, 8'hFF, 7'b0};
      2: return {s, 8'hFF, mt | 7'd1};
      3: return {s, 8'h00, mt | 7'd1};
      4: ex = 8'($urandom_range(240, 254));
      5: ex = 8'($urandom_range(1, 10));
      default: ;
    endcase
    return {s, ex, mt};
  endfunction

  initial begin
    logic [15:0] ra, rb, pa, pb;
    rst = 1'b1;
    a_in = '0; b_in = '0; a_vld_in = 0; b_vld_in = 0;
    acc_clr = 0; drain = 0; c_in = '0; c_vld_in = 0;
    do_reset();
    chk("reset_c_out", c_out, 32'h0);

    // single product 1.5 * 2.0
    mac(16'h3FC0, 16'h4000, 1'b1);
    chk("fwd_a_out", {16'b0, a_out}, 32'h3FC0);
    idle();
    do_drain();
    chk("single_product", c_out, 32'h40400000);
    chk("single_vld", {31'b0, c_vld_out}, 32'h1);

    // four back-to-back 1.0 * 1.0
    mac(16'h3F80, 16'h3F80, 1'b1);
    repeat (3) mac(16'h3F80, 16'h3F80, 1'b0);
    idle(); idle();
    do_drain();
    chk("b2b_accumulate", c_out, 32'h40800000);

    // specials
    mac(16'h7F80, 16'h0000, 1'b1); idle(); do_drain();
    chk("inf_times_zero", c_out, 32'h7FC00000);
    mac(16'h7F80, 16'h3F80, 1'b1); mac(16'hFF80, 16'h3F80, 1'b0); idle(); do_drain();
    chk("inf_minus_inf", c_out, 32'h7FC00000);
    mac(16'h7F00, 16'h7F00, 1'b1); idle(); do_drain();
    chk("mul_overflow", c_out, 32'h7F800000);
    mac(16'h0040, 16'h3F80, 1'b1); idle(); do_drain();
    chk("subnormal_in", c_out, 32'h00000000);
    mac(16'h3F80, 16'h3F80, 1'b1); mac(16'hBF80, 16'h3F80, 1'b0); idle(); do_drain();
    chk("cancel_pos_zero", c_out, 32'h00000000);

    // rounding tie 2^24 + 1 -> 2^24
    mac(16'h4B80, 16'h3F80, 1'b1); mac(16'h3F80, 16'h3F80, 1'b0); idle(); do_drain();
    chk("round_tie_even", c_out, 32'h4B800000);

    // drain overlap: MACs in cycles 0..5, drain at cycle 4
    mac(16'h3F80, 16'h3F80, 1'b1);
    mac(16'h3F80, 16'h3F80, 1'b0);
    mac(16'h3F80, 16'h3F80, 1'b0);
    mac(16'h3F80, 16'h3F80, 1'b0);
    cyc(16'h3F80, 1'b1, 16'h3F80, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    chk("drain_overlap_old", c_out, 32'h40400000);
    mac(16'h3F80, 16'h3F80, 1'b0);
    idle(); idle(); do_drain();
    chk("drain_overlap_new", c_out, 32'h40400000);
    cyc(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    chk("pass_through", c_out, 32'hDEADBEEF);

    // reset mid-MAC
    mac(16'h4040, 16'h4040, 1'b1);
    do_reset();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_c_vld", {31'b0, c_vld_out}, 32'h0);
    idle(); do_drain();
    chk("drain_after_rst", c_out, 32'h0);

    // randomized traffic
    pa = 16'h3F80; pb = 16'h3F80;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        ra = pa ^ 16'h8000; rb = pb;
      end else begin
        ra = rnd_bf16(); rb = rnd_bf16();
      end
      cyc(ra, ($urandom_range(0, 3) != 0), rb, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
          32'($urandom), 1'($urandom_range(0, 1)));
      pa = ra; pb = rb;
    end
    idle(); idle(); do_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
